// File: rtl/led_event_blinker_pkg.sv
// Shared definitions for the LED blinker and later LED/display blocks.
//   blink_state_e : IDLE / ON / OFF phase encoding
//   max_u         : larger of two unsigned values, for parameter sizing
//   timer_width   : bits needed to hold values 0..n-1, at least 1
package led_event_blinker_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } blink_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned timer_width(input int unsigned n);
    return max_u(1, $clog2(n));
  endfunction

endpackage

// File: rtl/led_event_blinker_cycle_timer.sv
// Loadable down-counter that stops at zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value loaded on load
//   en         : count down by one per cycle while non-zero
//   zero       : count is currently zero
module led_event_blinker_cycle_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && !zero) begin
      count_q <= count_q - One;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into visible LED blinks: one ON period then
// one OFF gap per accepted event. Events arriving mid-blink are queued in a
// saturating counter so bursts appear as a countable train of blinks.
//   clk, rst_n : clock, asynchronous active-low reset
//   evt        : event strobe, each high cycle is one event
//   led        : LED drive (registered)
//   busy       : high while not idle (registered)
//   pending    : queued, not yet started blinks (registered)
//   drop       : one-cycle pulse, an event was discarded on a full queue
module led_event_blinker
  import led_event_blinker_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 1250000,
  parameter int unsigned OFF_CYCLES = 1250000,
  parameter int unsigned PEND_MAX   = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          evt,
  output logic                          led,
  output logic                          busy,
  output logic [$clog2(PEND_MAX+1)-1:0] pending,
  output logic                          drop
);

  localparam int unsigned TimerW = timer_width(max_u(ON_CYCLES, OFF_CYCLES));
  localparam int unsigned PendW  = $clog2(PEND_MAX + 1);

  localparam logic [TimerW-1:0] OnLoad  = TimerW'(ON_CYCLES - 1);
  localparam logic [TimerW-1:0] OffLoad = TimerW'(OFF_CYCLES - 1);
  localparam logic [PendW-1:0]  PendMax = PendW'(PEND_MAX);
  localparam logic [PendW-1:0]  PendOne = PendW'(1);

  blink_state_e      state_q, state_d;
  logic [PendW-1:0]  pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              led_q, busy_q;

  logic              tmr_load;
  logic [TimerW-1:0] tmr_load_val;
  logic              tmr_zero;
  logic              queue_evt;

  led_event_blinker_cycle_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (state_q != StIdle),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    drop_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = OnLoad;
    queue_evt    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (evt) begin
          state_d  = StOn;
          tmr_load = 1'b1;
        end
      end
      StOn: begin
        queue_evt = evt;
        if (tmr_zero) begin
          state_d      = StOff;
          tmr_load     = 1'b1;
          tmr_load_val = OffLoad;
        end
      end
      StOff: begin
        if (tmr_zero) begin
          // Last OFF cycle: a simultaneous event is consumed directly by the
          // restart, so the queue never grows here and nothing is dropped.
          if ((pend_q != '0) || evt) begin
            state_d  = StOn;
            tmr_load = 1'b1;
            if (!evt) begin
              pend_d = pend_q - PendOne;
            end
          end else begin
            state_d = StIdle;
          end
        end else begin
          queue_evt = evt;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (queue_evt) begin
      if (pend_q < PendMax) begin
        pend_d = pend_q + PendOne;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      led_q   <= (state_d == StOn);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign drop    = drop_q;

endmodule

// File: tb/tb_led_event_blinker.sv
module tb_led_event_blinker;

  logic       clk;
  logic       rst_n;
  logic       evt;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       drop;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       evt;
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  led_event_blinker #(
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .PEND_MAX   (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt     (evt),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Append n identical cycle vectors: input evt and expected outputs that cycle.
  task automatic rep(input int n, input logic e, input logic l, input logic b,
                     input logic [1:0] p, input logic d);
    vec_t v;
    v.evt = e; v.led = l; v.busy = b; v.pend = p; v.drop = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int lit;

    // Single event
    rep(1, 1, 0, 0, 0, 0);
    rep(3, 0, 1, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 0);
    rep(2, 0, 0, 0, 0, 0);
    // Burst of four: two queued, fourth dropped, three blinks total
    rep(1, 1, 0, 0, 0, 0);
    rep(1, 1, 1, 1, 0, 0);
    rep(1, 1, 1, 1, 1, 0);
    rep(1, 1, 1, 1, 2, 0);
    rep(1, 0, 0, 1, 2, 1);
    rep(1, 0, 0, 1, 2, 0);
    rep(3, 0, 1, 1, 1, 0);
    rep(2, 0, 0, 1, 1, 0);
    rep(3, 0, 1, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 0);
    rep(1, 0, 0, 0, 0, 0);
    // Event in last OFF cycle with empty queue: restart without idle
    rep(1, 1, 0, 0, 0, 0);
    rep(3, 0, 1, 1, 0, 0);
    rep(1, 0, 0, 1, 0, 0);
    rep(1, 1, 0, 1, 0, 0);
    rep(3, 0, 1, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 0);
    rep(1, 0, 0, 0, 0, 0);
    // Full queue plus event in last OFF cycle: no drop, queue stays full
    rep(1, 1, 0, 0, 0, 0);
    rep(1, 1, 1, 1, 0, 0);
    rep(1, 1, 1, 1, 1, 0);
    rep(1, 0, 1, 1, 2, 0);
    rep(1, 0, 0, 1, 2, 0);
    rep(1, 1, 0, 1, 2, 0);
    rep(3, 0, 1, 1, 2, 0);
    rep(2, 0, 0, 1, 2, 0);
    rep(3, 0, 1, 1, 1, 0);
    rep(2, 0, 0, 1, 1, 0);
    rep(3, 0, 1, 1, 0, 0);
    rep(2, 0, 0, 1, 0, 0);
    rep(2, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    evt   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.led", led, 0);
    check("reset.busy", busy, 0);
    check("reset.pending", pending, 0);
    check("reset.drop", drop, 0);
    rst_n = 1'b1;

    // First vector's event is sampled on the first edge after release.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1 evt = vecs[i].evt;
      @(negedge clk);
      check($sformatf("vec[%0d].led", i), led, vecs[i].led);
      check($sformatf("vec[%0d].busy", i), busy, vecs[i].busy);
      check($sformatf("vec[%0d].pending", i), pending, vecs[i].pend);
      check($sformatf("vec[%0d].drop", i), drop, vecs[i].drop);
    end

    // Asynchronous reset mid-blink with one event queued.
    @(posedge clk); #1 evt = 1'b1;
    @(posedge clk); #1 evt = 1'b1;
    @(posedge clk); #1 evt = 1'b0;
    @(negedge clk);
    check("pre_rst.led", led, 1);
    check("pre_rst.pending", pending, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.led", led, 0);
    check("async_rst.busy", busy, 0);
    check("async_rst.pending", pending, 0);
    check("async_rst.drop", drop, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Normal single blink after release; the lost queued event must not replay.
    @(posedge clk); #1 evt = 1'b1;
    @(posedge clk); #1 evt = 1'b0;
    lit = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (led) lit++;
      @(posedge clk);
    end
    @(negedge clk);
    check("post_rst.led_cycles", lit, 3);
    check("post_rst.busy", busy, 0);
    check("post_rst.pending", pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
